// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game: movement direction,
// PS/2 set-2 scan codes and the frame receiver state encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  // Prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Plain letter keys W/S/A/D and Esc
  localparam logic [7:0] SC_W   = 8'h1D;
  localparam logic [7:0] SC_S   = 8'h1B;
  localparam logic [7:0] SC_A   = 8'h1C;
  localparam logic [7:0] SC_D   = 8'h23;
  localparam logic [7:0] SC_ESC = 8'h76;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } rx_state_e;

  // Direction that would make the snake reverse onto itself.
  function automatic dir_t opposite(dir_t d);
    dir_t r;
    unique case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw keyboard lines, debounces the
// keyboard clock, shifts in 11-bit frames on its falling edges and reports
// either a validated byte or a framing error.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYC + 1);

  logic             clk_meta_q, clk_sync_q;
  logic             data_meta_q, data_sync_q;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall_q, fall_d;

  rx_state_e        state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
        fall_d = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state and the registered falling-edge pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
    end
  end

  // Frame FSM: start bit, 8 data bits, parity, stop, then a one-cycle check.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    to_cnt_d     = to_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (fall_q) begin
          if (!data_sync_q) begin
            state_d = StShift;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StShift: begin
        // Terminal count takes priority over a coincident edge.
        if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
          state_d     = StIdle;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
        end else if (fall_q) begin
          to_cnt_d = '0;
          // LSB-first: after 10 shifts [7:0]=data, [8]=parity, [9]=stop.
          shreg_d  = {data_sync_q, shreg_q[9:1]};
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            state_d   = StCheck;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if ((^shreg_q[8:0]) && shreg_q[9]) begin
          byte_valid_d = 1'b1;
          rx_byte_d    = shreg_q[7:0];
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      to_cnt_q     <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      to_cnt_q     <= to_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte_o    = rx_byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// Keyboard front end for the snake game: turns PS/2 make/break sequences
// into a registered movement direction with change and Esc strobes.
module ps2_dir_decoder
  import snake_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2CLK,
  input  logic       PS2Data,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       esc,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  dir_t       dir_q, dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic       esc_q, esc_d;
  logic       req_valid;
  dir_t       req_dir;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk_i    (PS2CLK),
    .ps2_data_i   (PS2Data),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err)
  );

  // Scan-code decode and direction update rules.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    esc_d       = 1'b0;
    req_valid   = 1'b0;
    req_dir     = UP;
    if (byte_valid) begin
      if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Break sequences release a key and never produce output.
        if (!brk_q) begin
          if (ext_q) begin
            case (rx_byte)
              SC_UP:    begin req_valid = 1'b1; req_dir = UP;    end
              SC_DOWN:  begin req_valid = 1'b1; req_dir = DOWN;  end
              SC_LEFT:  begin req_valid = 1'b1; req_dir = LEFT;  end
              SC_RIGHT: begin req_valid = 1'b1; req_dir = RIGHT; end
              default:  ;
            endcase
          end else begin
            case (rx_byte)
              SC_W:    begin req_valid = 1'b1; req_dir = UP;    end
              SC_S:    begin req_valid = 1'b1; req_dir = DOWN;  end
              SC_A:    begin req_valid = 1'b1; req_dir = LEFT;  end
              SC_D:    begin req_valid = 1'b1; req_dir = RIGHT; end
              SC_ESC:  esc_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
    // Repeats and reversals are dropped silently.
    if (req_valid && (req_dir != dir_q) && (req_dir != opposite(dir_q))) begin
      dir_d       = req_dir;
      dir_valid_d = 1'b1;
    end
  end

  // Prefix flags, direction register and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      dir_q       <= RIGHT;
      dir_valid_q <= 1'b0;
      esc_q       <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      esc_q       <= esc_d;
    end
  end

  assign dir       = dir_q;
  assign dir_valid = dir_valid_q;
  assign esc       = esc_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Randomised bench for ps2_dir_decoder with a table-driven keyboard model.
module tb_ps2_dir_decoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 3000;
  localparam int          HALF = 20;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [1:0] dir;
  logic       dir_valid;
  logic       esc;
  logic       frame_err;

  ps2_dir_decoder #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PS2CLK    (ps2_clk),
    .PS2Data   (ps2_data),
    .dir       (dir),
    .dir_valid (dir_valid),
    .esc       (esc),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Strobe monitor: running counts plus width/overlap violations.
  int   cyc         = 0;
  int   dv_cnt      = 0;
  int   esc_cnt     = 0;
  int   fe_cnt      = 0;
  int   viol        = 0;
  int   last_dv_cyc = 0;
  logic dv_prev     = 1'b0;
  logic esc_prev    = 1'b0;
  logic fe_prev     = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dir_valid === 1'b1) begin
      dv_cnt      <= dv_cnt + 1;
      last_dv_cyc <= cyc;
    end
    if (esc === 1'b1) esc_cnt <= esc_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if ((dir_valid === 1'b1 && esc === 1'b1) || (dir_valid === 1'b1 && dv_prev) ||
        (esc === 1'b1 && esc_prev) || (frame_err === 1'b1 && fe_prev))
      viol <= viol + 1;
    dv_prev  <= (dir_valid === 1'b1);
    esc_prev <= (esc === 1'b1);
    fe_prev  <= (frame_err === 1'b1);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keyboard model: key table, opposite-direction table, pending prefixes.
  logic [7:0] key_code [9] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h76};
  bit         key_ext  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  int         key_act  [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 4};  // 4 = Esc
  int         opp      [4] = '{1, 0, 3, 2};
  int         m_dir = 3;
  logic [7:0] m_pre[$];
  int         e_dv, e_esc, e_fe;

  task automatic model_frame(input logic [7:0] b, input bit err);
    bit is_ext, is_brk;
    int req;
    e_dv = 0; e_esc = 0; e_fe = 0; req = -1;
    if (err) begin
      e_fe = 1;
      return;
    end
    if (b == 8'hE0 || b == 8'hF0) begin
      m_pre.push_back(b);
      return;
    end
    is_ext = 0; is_brk = 0;
    foreach (m_pre[i]) begin
      if (m_pre[i] == 8'hE0) is_ext = 1;
      if (m_pre[i] == 8'hF0) is_brk = 1;
    end
    m_pre.delete();
    if (is_brk) return;
    for (int k = 0; k < 9; k++)
      if (key_ext[k] == is_ext && key_code[k] == b) req = key_act[k];
    if (req == 4) e_esc = 1;
    else if (req >= 0 && req != m_dir && req != opp[m_dir]) begin
      m_dir = req;
      e_dv  = 1;
    end
  endtask

  int edge_cyc = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input bit v);
    ps2_data = v;
    wait_cyc(HALF);
    ps2_clk  = 1'b0;
    edge_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bp, input bit bs);
    int dv0, es0, fe0;
    model_frame(b, bp | bs);
    dv0 = dv_cnt; es0 = esc_cnt; fe0 = fe_cnt;
    send_bits(b, bp, bs, 11);
    wait_cyc(HALF + 20);
    chk({tag, "_dv"},  32'(dv_cnt - dv0),  32'(e_dv));
    chk({tag, "_esc"}, 32'(esc_cnt - es0), 32'(e_esc));
    chk({tag, "_fe"},  32'(fe_cnt - fe0),  32'(e_fe));
    chk({tag, "_dir"}, 32'(dir),           32'(m_dir));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h76, 8'hE0, 8'hE0, 8'hF0};

  initial begin
    int         fe0, dv0, es0, waited, lat, sel;
    logic [7:0] rb;
    bit         bp, bs;

    // Reset
    rst_n = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(2);
    chk("rst_dir", 32'(dir), 32'd3);
    chk("rst_dv",  32'(dir_valid), 32'd0);
    chk("rst_esc", 32'(esc), 32'd0);
    chk("rst_fe",  32'(frame_err), 32'd0);
    wait_cyc(20);

    // First keys: A reverses right (ignored), W turns up
    do_frame("a_rev", 8'h1C, 0, 0);
    do_frame("w_up",  8'h1D, 0, 0);
    lat = last_dv_cyc - edge_cyc;
    chk("dv_latency", 32'(lat >= int'(FL) + 2 && lat <= int'(FL) + 8), 32'd1);

    // Extended arrows and a break sequence
    do_frame("a_left",  8'h1C, 0, 0);
    do_frame("e0",      8'hE0, 0, 0);
    do_frame("ext_dn",  8'h72, 0, 0);
    do_frame("brk_e0",  8'hE0, 0, 0);
    do_frame("brk_f0",  8'hF0, 0, 0);
    do_frame("brk_72",  8'h72, 0, 0);

    // Parity and stop errors
    do_frame("bad_par",  8'h75, 1, 0);
    do_frame("bad_stop", 8'h1C, 0, 1);

    // Reach up, then a timed-out partial frame, then D
    do_frame("to_left", 8'h1C, 0, 0);
    do_frame("to_up",   8'h1D, 0, 0);
    fe0 = fe_cnt; dv0 = dv_cnt;
    send_bits(8'h55, 0, 0, 5);
    waited = 0;
    while (fe_cnt == fe0 && waited < int'(TO) + 500) begin
      wait_cyc(1);
      waited++;
    end
    wait_cyc(20);
    chk("timeout_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("timeout_when", 32'(waited > int'(TO) - 200 && waited <= int'(TO) + 50), 32'd1);
    chk("timeout_dv", 32'(dv_cnt - dv0), 32'd0);
    do_frame("after_to", 8'h23, 0, 0);

    // Glitch on the keyboard clock with data low: must not start a frame
    fe0 = fe_cnt;
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(20);
    chk("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    do_frame("post_glitch", 8'h1B, 0, 0);

    // Esc
    do_frame("esc", 8'h76, 0, 0);

    // Reset mid-frame
    send_bits(8'h1C, 0, 0, 4);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("midrst_dir", 32'(dir), 32'd3);
    chk("midrst_dv",  32'(dir_valid), 32'd0);
    chk("midrst_esc", 32'(esc), 32'd0);
    chk("midrst_fe",  32'(frame_err), 32'd0);
    rst_n = 1'b1;
    m_dir = 3;
    m_pre.delete();
    wait_cyc(20);
    do_frame("post_rst", 8'h1D, 0, 0);

    // Random traffic
    for (int n = 0; n < 50; n++) begin
      sel = $urandom_range(0, 13);
      if (sel < 12) rb = pool[sel];
      else rb = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      do_frame("rand", rb, bp, bs);
    end

    chk("strobe_rules", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_dir_decoder.md
# ps2_dir_decoder

Upstream input stage of the snake game. Receives raw PS/2 keyboard clock and data and recovers validated 11-bit frames. Decodes make/break scan-code sequences into a registered 2-bit movement direction plus single-cycle event strobes. Its outputs feed the snake state machine directly, replacing ad-hoc keyboard sampling there.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized samples required before the filtered PS2CLK level changes.
- `TIMEOUT_CYC`, default 200_000: idle clk cycles (2 ms at 100 MHz) after which a partial frame is discarded.
- `clk`  in  1  system clock, 100 MHz; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `PS2CLK`  in  1  raw keyboard clock, asynchronous, open-drain.
- `PS2Data`  in  1  raw keyboard data, asynchronous.
- `dir`  out  2  current direction: 00 up, 01 down, 10 left, 11 right. Reset value 11 (right).
- `dir_valid`  out  1  one-cycle strobe when `dir` changes value. Reset value 0.
- `esc`  out  1  one-cycle strobe on Esc make code. Reset value 0.
- `frame_err`  out  1  one-cycle strobe on a parity, start or stop error, or on a timeout. Reset value 0.

## Operation
- **Input conditioning**
  - PS2CLK and PS2Data each pass through a 2-FF synchronizer.
  - PS2CLK then goes through a saturating filter: the filtered level flips only after `FILTER_LEN` equal samples.
  - `fall` is a one-cycle pulse on a filtered 1->0 transition.
- **Frame FSM**
  - States: IDLE, SHIFT, CHECK.
  - IDLE -> SHIFT on `fall` when data = 0 (start bit). If data = 1 on `fall`, stay in IDLE and pulse `frame_err`.
  - SHIFT: capture 8 data bits LSB-first, then the parity bit, then the stop bit, one bit per `fall` (4-bit counter).
  - SHIFT -> CHECK after the stop bit is captured.
  - CHECK (one cycle): odd parity over data+parity must hold and stop must be 1. If OK, pulse `byte_valid` with `byte`; otherwise pulse `frame_err`. Always return to IDLE.
  - Timeout counter clears on every `fall` and runs only in SHIFT. Reaching `TIMEOUT_CYC` returns to IDLE, clears the bit count and pulses `frame_err`.
- **Scan decoder** (consumes `byte_valid`)
  - Flags `ext` (after E0) and `brk` (after F0). Both clear after the next non-prefix byte.
  - Make codes with `brk` = 0:
    - E0 75 and 1D (W) -> up.
    - E0 72 and 1B (S) -> down.
    - E0 6B and 1C (A) -> left.
    - E0 74 and 23 (D) -> right.
    - 76 -> `esc`.
  - Break sequences (F0 xx, E0 F0 xx) produce no output.
  - Unknown codes are ignored.
- **Direction rules**
  - A request equal to the current `dir` is ignored, with no strobe.
  - A request exactly opposite the current `dir` (up<->down, left<->right) is ignored.
  - Otherwise `dir` updates and `dir_valid` pulses in the same cycle.
- Reset clears the synchronizers (to 1), filter, FSM (to IDLE), flags, counters and all outputs to their reset values. Reset mid-frame discards the partial byte.

## Timing
- Synchronizer to `fall`: 2 cycles plus `FILTER_LEN` cycles.
- `fall` of the stop bit -> CHECK on the next cycle -> `byte_valid` on the cycle after that.
- `dir`, `dir_valid` and `esc` are registered on the cycle after `byte_valid`. Total latency from stop-bit `fall` to `dir_valid` is 3 cycles.
- Strobes are exactly 1 cycle wide. `dir_valid` and `esc` are never asserted together.
- `frame_err` from CHECK and from the timeout cannot coincide, because the timeout counter runs only in SHIFT.
- A `fall` arriving in the same cycle as the timeout terminal count: the timeout wins and the edge is dropped.

## Structure
- `snake_pkg`: direction enum `dir_t` (UP, DOWN, LEFT, RIGHT with the encodings above), scan-code constants (`SC_E0`, `SC_F0`, `SC_UP`, `SC_ESC`, …) and `function opposite(dir_t)`. The snake state machine shares this package.
- Sub-module `ps2_frame_rx`: synchronizers, filter, frame FSM and timeout, with outputs `byte`, `byte_valid` and `frame_err`. The top level adds the scan decoder and direction register.

## Test plan
- **Reset and first key:** reset, then frame 0x1C (A) -> `dir` stays 11; this is a reversal of right, so no `dir_valid`. Then frame 0x1D (W) -> `dir` = 00 with a 1-cycle `dir_valid` 3 cycles after the stop edge.
- **Extended arrow and break:** E0 72 -> `dir` 01 with `dir_valid`. Then E0 F0 72 -> no strobes and `dir` stays 01.
- **Errors:** byte 0x75 sent with even parity -> `frame_err` pulse and `dir` unchanged. Stop bit forced to 0 -> `frame_err` pulse.
- **Timeout:** 5 bits then idle 200_000 cycles -> `frame_err` at the timeout and FSM in IDLE. A following valid 0x23 frame is decoded correctly: from `dir` = 00 it gives `dir` = 11.
- **Glitch rejection:** 3-cycle low pulse on PS2CLK (shorter than `FILTER_LEN`) -> no `fall` and no bit counted.
- **Esc and mid-frame reset:** 0x76 -> `esc` pulse only. `rst_n` low for 1 cycle after 4 bits -> all outputs at reset values, and the next complete frame decodes normally.
